// File: rtl/apb_fabric_pkg.sv
// apb_fabric_pkg: shared FSM states, error read data and slot decode for apb_fabric_mux
// No ports; imported by apb_fabric_mux and apb_fabric_timer.
package apb_fabric_pkg;
  typedef enum logic [2:0] {IDLE, DSETUP, DACCESS, ERR, RESP} state_e;
  localparam int ERR_RDATA = 0;
  function automatic logic [31:0] slot_of(input logic [63:0] addr, input int unsigned lsb,
                                          input int unsigned bits);
    return 32'((addr >> lsb) & ((64'd1 << bits) - 64'd1));
  endfunction
endpackage

// File: rtl/apb_fabric_timer.sv
// apb_fabric_timer: DACCESS cycle counter flagging when TIMEOUT cycles have elapsed
// Ports: clk/rst sync active-high; clear_i zeroes the count, enable_i advances it,
// expired_o is high on the TIMEOUT-th counted cycle.
module apb_fabric_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);
  localparam int W = $clog2(TIMEOUT);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clear_i ? '0 : enable_i ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign expired_o = cnt_q == W'(TIMEOUT - 1);
endmodule

// File: rtl/apb_fabric_mux.sv
// apb_fabric_mux: registered APB3 decoder from the MSS fabric master to N_SLAVES peripherals
// Ports: SYSCLK/SYSRESET (sync, active-high); MSSP* upstream slave port; S_P* downstream
// master port with one-hot S_PSEL and per-slave packed S_PRDATA/S_PREADY/S_PSLVERR.
// Build option: define APB_FABRIC_MUX_TIMEOUT_EN to error out slaves that stall for TIMEOUT cycles.
module apb_fabric_mux
  import apb_fabric_pkg::*;
#(
  parameter int N_SLAVES  = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int SLOT_LSB  = 8,
  parameter int SLOT_BITS = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic                       SYSCLK,
  input  logic                       SYSRESET,
  input  logic                       MSSPSEL,
  input  logic                       MSSPENABLE,
  input  logic                       MSSPWRITE,
  input  logic [ADDR_W-1:0]          MSSPADDR,
  input  logic [DATA_W-1:0]          MSSPWDATA,
  output logic [DATA_W-1:0]          MSSPRDATA,
  output logic                       MSSPREADY,
  output logic                       MSSPSLVERR,
  output logic [N_SLAVES-1:0]        S_PSEL,
  output logic                       S_PENABLE,
  output logic                       S_PWRITE,
  output logic [ADDR_W-1:0]          S_PADDR,
  output logic [DATA_W-1:0]          S_PWDATA,
  input  logic [N_SLAVES*DATA_W-1:0] S_PRDATA,
  input  logic [N_SLAVES-1:0]        S_PREADY,
  input  logic [N_SLAVES-1:0]        S_PSLVERR
);
  if (TIMEOUT < 2 || N_SLAVES < 1 || N_SLAVES > (1 << SLOT_BITS)) begin : g_bad_cfg
    $error("apb_fabric_mux: invalid TIMEOUT/N_SLAVES/SLOT_BITS");
  end
  state_e              state_q;
  logic [N_SLAVES-1:0] sel_q;
  logic                en_q, wr_q, rdy_q, err_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q, sel_rdata;
  logic [31:0]         slot;
  logic                sel_rdy, sel_err, expired;
  assign slot = slot_of(64'(MSSPADDR), SLOT_LSB, SLOT_BITS);
  // The one-hot select doubles as the slot index while downstream is active.
  assign sel_rdy = |(S_PREADY & sel_q);
  assign sel_err = |(S_PSLVERR & sel_q);
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < N_SLAVES; i++) sel_rdata |= sel_q[i] ? S_PRDATA[i*DATA_W +: DATA_W] : '0;
  end
`ifdef APB_FABRIC_MUX_TIMEOUT_EN
  apb_fabric_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (SYSCLK),
    .rst      (SYSRESET),
    .clear_i  (state_q == DSETUP),
    .enable_i (state_q == DACCESS),
    .expired_o(expired)
  );
`else
  assign expired = 1'b0;
`endif
  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) begin
      state_q <= IDLE;
      sel_q   <= '0;
      en_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else if (state_q != IDLE && !MSSPSEL) begin
      // Master abandoned the transfer: drop everything without a response.
      state_q <= IDLE;
      sel_q   <= '0;
      en_q    <= 1'b0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (MSSPSEL && !MSSPENABLE) begin
          wr_q    <= MSSPWRITE;
          addr_q  <= MSSPADDR;
          wdata_q <= MSSPWDATA;
          if (slot < 32'(N_SLAVES)) begin
            state_q <= DSETUP;
            sel_q   <= N_SLAVES'(1) << slot;
          end else state_q <= ERR;
        end
        DSETUP: begin
          state_q <= DACCESS;
          en_q    <= 1'b1;
        end
        DACCESS: if (sel_rdy || expired) begin
          state_q <= RESP;
          sel_q   <= '0;
          en_q    <= 1'b0;
          rdy_q   <= 1'b1;
          rdata_q <= sel_rdy && !wr_q ? sel_rdata : DATA_W'(ERR_RDATA);
          err_q   <= sel_rdy ? sel_err : 1'b1;
        end
        ERR: begin
          state_q <= RESP;
          rdy_q   <= 1'b1;
          rdata_q <= DATA_W'(ERR_RDATA);
          err_q   <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          rdy_q   <= 1'b0;
          rdata_q <= '0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end
  assign MSSPRDATA  = rdata_q;
  assign MSSPREADY  = rdy_q;
  assign MSSPSLVERR = err_q;
  assign S_PSEL     = sel_q;
  assign S_PENABLE  = en_q;
  assign S_PWRITE   = wr_q;
  assign S_PADDR    = addr_q;
  assign S_PWDATA   = wdata_q;
endmodule

// File: tb/tb_apb_fabric_mux.sv
// tb_apb_fabric_mux: directed table, corner sequences and random transfers for apb_fabric_mux
module tb_apb_fabric_mux;
  localparam int N = 4, AW = 32, DW = 32, SL = 8, TO = 16;
`ifdef APB_FABRIC_MUX_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic SYSCLK = 1'b0, SYSRESET = 1'b1;
  logic MSSPSEL = 1'b0, MSSPENABLE = 1'b0, MSSPWRITE = 1'b0;
  logic [AW-1:0] MSSPADDR = '0;
  logic [DW-1:0] MSSPWDATA = '0;
  logic [DW-1:0] MSSPRDATA;
  logic MSSPREADY, MSSPSLVERR;
  logic [N-1:0] S_PSEL, S_PREADY, S_PSLVERR;
  logic S_PENABLE, S_PWRITE;
  logic [AW-1:0] S_PADDR;
  logic [DW-1:0] S_PWDATA;
  logic [N*DW-1:0] S_PRDATA;
  int vecs = 0, miss = 0;
  int wait_c = 0, acc = 0;
  logic [DW-1:0] prd [N];
  logic [N-1:0] perr = '0;

  apb_fabric_mux #(.N_SLAVES(N), .ADDR_W(AW), .DATA_W(DW), .SLOT_LSB(SL), .SLOT_BITS(4),
                   .TIMEOUT(TO)) dut (
    .SYSCLK(SYSCLK), .SYSRESET(SYSRESET), .MSSPSEL(MSSPSEL), .MSSPENABLE(MSSPENABLE),
    .MSSPWRITE(MSSPWRITE), .MSSPADDR(MSSPADDR), .MSSPWDATA(MSSPWDATA), .MSSPRDATA(MSSPRDATA),
    .MSSPREADY(MSSPREADY), .MSSPSLVERR(MSSPSLVERR), .S_PSEL(S_PSEL), .S_PENABLE(S_PENABLE),
    .S_PWRITE(S_PWRITE), .S_PADDR(S_PADDR), .S_PWDATA(S_PWDATA), .S_PRDATA(S_PRDATA),
    .S_PREADY(S_PREADY), .S_PSLVERR(S_PSLVERR));

  always #5 SYSCLK = ~SYSCLK;

  // Slave model: the selected slave answers after wait_c access cycles.
  always @(posedge SYSCLK) acc <= (S_PENABLE && S_PSEL != '0) ? acc + 1 : 0;
  assign S_PREADY  = (S_PENABLE && acc >= wait_c) ? S_PSEL : '0;
  assign S_PSLVERR = perr;
  always_comb for (int i = 0; i < N; i++) S_PRDATA[i*DW +: DW] = prd[i];

  typedef struct {
    bit          wr;
    logic [31:0] addr, wd;
    int          w;
    logic [31:0] prd;
    bit          perr;
    int          lat;
    logic [31:0] rd;
    bit          er;
    logic [N-1:0] sel;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".up"}, 64'({MSSPRDATA, MSSPREADY, MSSPSLVERR}), 64'd0);
    chk({nm, ".dn"}, 64'({S_PSEL, S_PENABLE, S_PWRITE}), 64'd0);
    chk({nm, ".paddr"}, 64'(S_PADDR), 64'd0);
    chk({nm, ".pwdata"}, 64'(S_PWDATA), 64'd0);
  endtask

  // Reference: latency counted in cycles from the upstream setup cycle T0.
  function automatic void model(input bit wr, input logic [31:0] addr, input int w,
                                output int lat, output logic [31:0] rd, output bit er,
                                output logic [N-1:0] sel);
    int s = int'(addr[SL +: 4]);
    bit to;
    if (s >= N) begin
      lat = 2; rd = 0; er = 1; sel = '0;
      return;
    end
    sel = N'(1) << s;
    to  = TO_EN && w >= TO;
    lat = to ? 2 + TO : 3 + w;
    rd  = (to || wr) ? 32'd0 : prd[s];
    er  = to || perr[s];
  endfunction

  task automatic start(input bit wr, input logic [31:0] addr, input logic [31:0] wd);
    @(negedge SYSCLK);
    MSSPSEL = 1'b1; MSSPENABLE = 1'b0; MSSPWRITE = wr; MSSPADDR = addr; MSSPWDATA = wd;
    @(negedge SYSCLK);
    MSSPENABLE = 1'b1;
  endtask

  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                      input int elat, input logic [31:0] erd, input bit eer,
                      input logic [N-1:0] esel, input string nm);
    int n;
    start(wr, addr, wd);
    n = 1;
    chk({nm, ".psel"}, 64'(S_PSEL), 64'(esel));
    chk({nm, ".pwrite"}, 64'(S_PWRITE), 64'(wr));
    chk({nm, ".paddr"}, 64'(S_PADDR), 64'(addr));
    chk({nm, ".pwdata"}, 64'(S_PWDATA), 64'(wd));
    while (!MSSPREADY && n < 300) begin
      @(negedge SYSCLK);
      n++;
    end
    chk({nm, ".latency"}, 64'(n), 64'(elat));
    chk({nm, ".rdata"}, 64'(MSSPRDATA), 64'(erd));
    chk({nm, ".slverr"}, 64'(MSSPSLVERR), 64'(eer));
    MSSPSEL = 1'b0; MSSPENABLE = 1'b0;
    @(negedge SYSCLK);
    chk({nm, ".after"}, 64'({MSSPRDATA, MSSPREADY, MSSPSLVERR, S_PSEL, S_PENABLE}), 64'd0);
  endtask

  task automatic setup_slaves(input logic [31:0] addr, input int w, input logic [31:0] p,
                              input bit e);
    int s = int'(addr[SL +: 4]);
    for (int i = 0; i < N; i++) prd[i] = $urandom;
    perr = N'($urandom);
    wait_c = w;
    if (s < N) begin
      prd[s] = p;
      perr[s] = e;
    end
  endtask

  initial begin
    vec_t tbl[$];
    int rdy_seen, lat;
    logic [31:0] erd, addr;
    bit eer, wr;
    logic [N-1:0] esel;
    for (int i = 0; i < N; i++) prd[i] = '0;
    tbl.push_back('{1'b0, 32'h0000_0123, 32'h0, 0, 32'hCAFE_F00D, 1'b0, 3, 32'hCAFE_F00D, 1'b0, 4'b0010});
    tbl.push_back('{1'b1, 32'h0000_0310, 32'hA5A5_0001, 4, 32'h1111_2222, 1'b0, 7, 32'h0, 1'b0, 4'b1000});
    tbl.push_back('{1'b0, 32'h0000_0A00, 32'h0, 0, 32'h0, 1'b0, 2, 32'h0, 1'b1, 4'b0000});
    tbl.push_back('{1'b0, 32'h0000_0200, 32'h0, 1, 32'h1234_5678, 1'b1, 4, 32'h1234_5678, 1'b1, 4'b0100});
    tbl.push_back('{1'b0, 32'h0000_0004, 32'h0, 15, 32'h0BAD_BEEF, 1'b0, 18, 32'h0BAD_BEEF, 1'b0, 4'b0001});
    tbl.push_back('{1'b1, 32'hFFFF_F4FC, 32'h5555_AAAA, 0, 32'h0, 1'b0, 2, 32'h0, 1'b1, 4'b0000});
    tbl.push_back('{1'b1, 32'h0000_0100, 32'h0F0F_0F0F, 0, 32'hDEAD_0000, 1'b1, 3, 32'h0, 1'b1, 4'b0010});
    if (TO_EN)
      tbl.push_back('{1'b0, 32'h0000_0000, 32'h0, 1000, 32'h7777_7777, 1'b0, 18, 32'h0, 1'b1, 4'b0001});
    repeat (3) @(negedge SYSCLK);
    chk_zero("reset");
    SYSRESET = 1'b0;
    @(negedge SYSCLK);
    chk_zero("idle");
    foreach (tbl[k]) begin
      setup_slaves(tbl[k].addr, tbl[k].w, tbl[k].prd, tbl[k].perr);
      xfer(tbl[k].wr, tbl[k].addr, tbl[k].wd, tbl[k].lat, tbl[k].rd, tbl[k].er, tbl[k].sel,
           $sformatf("tbl%0d", k));
    end
    // Abort: master drops MSSPSEL during the first access cycle.
    setup_slaves(32'h0000_0040, 1000, 32'h0, 1'b0);
    start(1'b0, 32'h0000_0040, 32'h0);
    @(negedge SYSCLK);
    chk("abort.access", 64'({S_PSEL, S_PENABLE}), 64'({4'b0001, 1'b1}));
    MSSPSEL = 1'b0; MSSPENABLE = 1'b0;
    @(negedge SYSCLK);
    chk("abort.down", 64'({S_PSEL, S_PENABLE}), 64'd0);
    rdy_seen = 0;
    repeat (6) begin
      rdy_seen += int'(MSSPREADY);
      @(negedge SYSCLK);
    end
    chk("abort.noresp", 64'(rdy_seen), 64'd0);
    // Reset while the slave is stalling in access.
    start(1'b1, 32'h0000_0377, 32'h8765_4321);
    @(negedge SYSCLK);
    SYSRESET = 1'b1;
    @(negedge SYSCLK);
    chk_zero("midreset");
    SYSRESET = 1'b0; MSSPSEL = 1'b0; MSSPENABLE = 1'b0;
    @(negedge SYSCLK);
    if (!TO_EN) begin
      // With no timer a stalled slave holds the transfer open until the master gives up.
      setup_slaves(32'h0000_0000, 1000, 32'h0, 1'b0);
      start(1'b0, 32'h0000_0000, 32'h0);
      rdy_seen = 0;
      repeat (100) begin
        @(negedge SYSCLK);
        rdy_seen += int'(MSSPREADY);
      end
      chk("hang.noresp", 64'(rdy_seen), 64'd0);
      chk("hang.psel", 64'({S_PSEL, S_PENABLE}), 64'({4'b0001, 1'b1}));
      MSSPSEL = 1'b0; MSSPENABLE = 1'b0;
      @(negedge SYSCLK);
      chk("hang.abort", 64'({S_PSEL, S_PENABLE}), 64'd0);
    end
    for (int k = 0; k < 40; k++) begin
      int s = $urandom_range(0, 5);
      if (s >= N) s = $urandom_range(N, 15);
      addr = $urandom;
      addr[SL +: 4] = 4'(s);
      wr = 1'($urandom);
      setup_slaves(addr, $urandom_range(0, TO_EN ? 20 : 8), $urandom, 1'($urandom));
      model(wr, addr, wait_c, lat, erd, eer, esel);
      xfer(wr, addr, $urandom, lat, erd, eer, esel, $sformatf("rnd%0d", k));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
